// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//
// Contents:
//   feeder_state_e  - launch-controller state encoding
//   DEF_CLK_FREQ    - default system clock frequency in Hz
//   DEF_BAUD        - default line rate in baud
//   bit_cycles()    - clk cycles per UART bit, rounded to nearest
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQ       = 2'b01,
        WAIT_DONE = 2'b10
    } feeder_state_e;

    localparam int unsigned DEF_CLK_FREQ = 1000000;
    localparam int unsigned DEF_BAUD     = 9600;

    // Used when sizing the watchdog: TIMEOUT_CYC should cover at least 12 bit periods.
    function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                               input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy flags.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   wr_en     - push wr_data; ignored when full unless a read happens in the same cycle
//   wr_data   - byte to push
//   rd_en     - pop the head entry; ignored when empty
//   rd_data   - head entry, combinational from storage
//   full      - level == DEPTH (registered)
//   empty     - level == 0 (registered)
//   level     - occupancy, 0..DEPTH
module uart_byte_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0]   LvlFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LvlOne  = 1;
    localparam logic [ADDR_W-1:0] PtrOne  = 1;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, empty_q;
    logic              wr_ok, rd_ok;

    assign rd_ok = rd_en && !empty_q;
    // A pop in the same cycle frees the slot the write lands in.
    assign wr_ok = wr_en && (!full_q || rd_ok);

    always_comb begin
        level_d = level_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PtrOne;
            level_q <= level_d;
            full_q  <= (level_d == LvlFull);
            empty_q <= (level_d == '0);
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and launch controller in front of the UART transmitter.
// Bytes are launched one at a time: send is held until the start bit shows on
// tx_line, then the next launch waits for a rising edge of donetx. A watchdog
// aborts either wait after TIMEOUT_CYC cycles, discarding the byte.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   wr_en        - push wr_data into the queue
//   wr_data      - byte to queue
//   full, empty  - queue flags (registered)
//   level        - queue occupancy, 0..DEPTH
//   tx_line      - transmitter serial output, watched for the start bit
//   donetx       - transmitter completion flag
//   send         - launch request to the transmitter
//   dintx        - byte presented to the transmitter
//   busy         - a byte is in flight (state other than IDLE)
//   overflow     - sticky, a write was dropped
//   err_timeout  - sticky, a watchdog abort occurred
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 2048,
    parameter int unsigned TMR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    input  logic              tx_line,
    input  logic              donetx,
    output logic              send,
    output logic [7:0]        dintx,
    output logic              busy,
    output logic              overflow,
    output logic              err_timeout
);

    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TmrOne  = 1;

    feeder_state_e    state_q, state_d;
    logic             send_q, send_d;
    logic [7:0]       dintx_q, dintx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             donetx_q;
    logic             done_rise;

    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_rd_data;
    logic             pop;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign done_rise = donetx && !donetx_q;
    assign pop       = (state_q == IDLE) && !fifo_empty;
    assign ovf_d     = ovf_q || (wr_en && fifo_full && !pop);

    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        dintx_d = dintx_q;
        timer_d = timer_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    dintx_d = fifo_rd_data;
                    send_d  = 1'b1;
                    timer_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = timer_q + TmrOne;
                if (!tx_line) begin
                    send_d  = 1'b0;
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end else if (timer_q == TmrLast) begin
                    send_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                // send stays low here so the idle transmitter cannot relaunch this byte.
                send_d  = 1'b0;
                timer_d = timer_q + TmrOne;
                if (done_rise) begin
                    state_d = IDLE;
                end else if (timer_q == TmrLast) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                send_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            send_q   <= 1'b0;
            dintx_q  <= 8'h00;
            timer_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            donetx_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            send_q   <= send_d;
            dintx_q  <= dintx_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            donetx_q <= donetx;
        end
    end

    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign send        = send_q;
    assign dintx       = dintx_q;
    assign busy        = (state_q != IDLE);
    assign overflow    = ovf_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder. A small behavioural
// transmitter model answers each launch with a start bit and a donetx pulse.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned TIMEOUT_CYC = 2048;
    localparam int unsigned TMR_W       = 16;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              tx_line;
    logic              donetx;
    logic              send;
    logic [7:0]        dintx;
    logic              busy;
    logic              overflow;
    logic              err_timeout;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .tx_line     (tx_line),
        .donetx      (donetx),
        .send        (send),
        .dintx       (dintx),
        .busy        (busy),
        .overflow    (overflow),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // One clock; inputs set after this are seen at the next edge, outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Transmitter model: wait for send, answer with a start bit, then donetx.
    task automatic xmit(output logic [7:0] b);
        int   waited = 0;
        logic bad    = 1'b0;
        while (send !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        check("send_launch", 32'(send), 1);
        b = dintx;
        repeat (3) tick();
        check("send_held", 32'({send, dintx}), 32'({1'b1, b}));
        tx_line = 1'b0;
        tick();
        check("send_drop", 32'(send), 0);
        tx_line = 1'b1;
        repeat (6) begin
            tick();
            if (send !== 1'b0) bad = 1'b1;
        end
        check("send_in_wait", 32'(bad), 0);
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        check("busy_after_done", 32'(busy), 0);
    endtask

    initial begin
        logic [7:0] b;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_line = 1'b1;
        donetx  = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_send_busy", 32'({send, busy}), 0);
        check("rst_dintx", 32'(dintx), 0);
        check("rst_fifo", 32'({full, empty, level}), 'b0_1_00000);
        check("rst_sticky", 32'({overflow, err_timeout}), 0);
        rst = 1'b0;
        tick();

        // Single byte: write in N, send in N+2
        push(8'hA5);
        check("lat_n1_send", 32'(send), 0);
        tick();
        check("lat_n2_send", 32'({send, dintx}), 'h1A5);
        check("lat_n2_level", 32'(level), 0);
        // donetx rise while in REQ must be ignored
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        tick();
        check("req_ignore_done", 32'({send, busy}), 'b11);
        tx_line = 1'b0;
        tick();
        check("start_bit", 32'({send, busy}), 'b01);
        tx_line = 1'b1;
        repeat (20) tick();
        check("wait_hold", 32'({send, busy}), 'b01);
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        check("single_done", 32'({busy, empty, err_timeout}), 'b010);

        // Burst: first byte is popped while the second is written, so level peaks at 2
        wr_en   = 1'b1;
        wr_data = 8'h01;
        tick();
        wr_data = 8'h02;
        tick();
        wr_data = 8'h03;
        tick();
        wr_en = 1'b0;
        check("burst_level", 32'(level), 2);
        for (int k = 1; k <= 3; k++) begin
            xmit(b);
            check("burst_byte", 32'(b), 32'(k));
        end
        tick();
        check("burst_drained", 32'({busy, empty, level}), 'b0_1_00000);

        // Fill and overflow: byte 00 is in flight, 01..10 fill the FIFO, 11 is dropped
        do_reset();
        for (int i = 0; i < 18; i++) begin
            push(8'(i));
            if (i == 16) check("fill_full_no_ovf", 32'({full, overflow}), 'b10);
        end
        check("fill_flags", 32'({full, overflow, level}), 'b1_1_10000);
        for (int k = 0; k <= 16; k++) begin
            xmit(b);
            check("fill_order", 32'(b), 32'(k));
        end
        tick();
        check("fill_after", 32'({busy, empty, overflow}), 'b011);

        // Simultaneous write and pop at full
        do_reset();
        push(8'h80);
        tick();
        tx_line = 1'b0;
        tick();
        tx_line = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h90 + i));
        check("sim_full", 32'({full, level}), 'b1_10000);
        donetx = 1'b1;
        tick();
        donetx  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("sim_level", 32'({overflow, level}), 'b0_10000);
        check("sim_launch", 32'({send, dintx}), 'h190);
        for (int k = 0; k <= 16; k++) begin
            xmit(b);
            check("sim_order", 32'(b), (k < 16) ? 32'h90 + 32'(k) : 32'hEE);
        end

        // Watchdog in REQ: abort exactly TIMEOUT_CYC cycles after entry
        do_reset();
        push(8'h3C);
        tick();
        check("to_req_entry", 32'({send, dintx}), 'h13C);
        repeat (TIMEOUT_CYC - 1) tick();
        check("to_req_before", 32'({send, err_timeout}), 'b10);
        tick();
        check("to_req_abort", 32'({send, err_timeout, busy, level}), 'b010_00000);
        push(8'h5A);
        xmit(b);
        check("to_next_byte", 32'(b), 'h5A);
        check("to_sticky", 32'(err_timeout), 1);

        // Watchdog in WAIT_DONE
        do_reset();
        push(8'hC3);
        tick();
        tx_line = 1'b0;
        tick();
        tx_line = 1'b1;
        repeat (TIMEOUT_CYC - 1) tick();
        check("to_wait_before", 32'({busy, err_timeout}), 'b10);
        tick();
        check("to_wait_abort", 32'({busy, err_timeout, send}), 'b010);

        // Reset mid-transfer with five bytes queued
        for (int i = 0; i < 6; i++) push(8'(8'hB0 + i));
        tx_line = 1'b0;
        tick();
        tx_line = 1'b1;
        check("mid_state", 32'({busy, send, level}), 'b10_00101);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ctrl", 32'({send, busy, dintx}), 0);
        check("mid_rst_fifo", 32'({empty, full, level}), 'b10_00000);
        check("mid_rst_sticky", 32'({overflow, err_timeout}), 0);
        repeat (3) tick();
        check("mid_rst_idle", 32'({send, busy}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
